// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage bus access controller: request/ack data bus, load alignment, stall and error flags
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] MemWriteData_IN,
  input  logic [5:0]  MemControl_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [31:0] ALUResult_IN,
  input  logic [4:0]  WriteRegister_IN,
  input  logic        WriteEnable_IN,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ACK,
  output logic        MEM_STALL,
  output logic        MEM_ERROR,
  output logic [31:0] MemReadData_OUT,
  output logic [31:0] ALUResult_OUT,
  output logic [4:0]  WriteRegister_OUT,
  output logic        WriteEnable_OUT
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

  typedef enum logic [1:0] {IDLE, BUSY, DONE} memStateT;

  memStateT    state, stateNext;
  logic [7:0]  timeoutCnt, cntNext, cntInc;
  logic        abortFlag, abortNext;
  logic [5:0]  accType;
  logic [1:0]  addrLow;
  logic        capture, ackTake;

  logic        isLoadOp, isStoreOp, sizeByte, sizeHalf, sizeWord;
  logic        access, bad;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadResult;

  assign ALUResult_OUT     = ALUResult_IN;
  assign WriteRegister_OUT = WriteRegister_IN;
  assign WriteEnable_OUT   = WriteEnable_IN & ~MEM_ERROR;
  assign cntInc            = timeoutCnt + 8'd1;

  // Decode the incoming EXE/MEM access: legality, byte enables and lane-replicated store data.
  always_comb begin
    isLoadOp  = 1'b0;
    isStoreOp = 1'b0;
    sizeByte  = 1'b0;
    sizeHalf  = 1'b0;
    sizeWord  = 1'b0;
    case (MemControl_IN)
      OP_LB, OP_LBU: begin isLoadOp  = 1'b1; sizeByte = 1'b1; end
      OP_LH, OP_LHU: begin isLoadOp  = 1'b1; sizeHalf = 1'b1; end
      OP_LW:         begin isLoadOp  = 1'b1; sizeWord = 1'b1; end
      OP_SB:         begin isStoreOp = 1'b1; sizeByte = 1'b1; end
      OP_SH:         begin isStoreOp = 1'b1; sizeHalf = 1'b1; end
      OP_SW:         begin isStoreOp = 1'b1; sizeWord = 1'b1; end
      default:       ;
    endcase

    access = MemRead_IN | MemWrite_IN;
    bad    = (MemRead_IN & MemWrite_IN)
           | (MemRead_IN & ~isLoadOp)
           | (MemWrite_IN & ~isStoreOp)
           | (sizeHalf & ALUResult_IN[0])
           | (sizeWord & (|ALUResult_IN[1:0]));

    beNext    = 4'b1111;
    wdataNext = MemWriteData_IN;
    if (sizeByte) begin
      beNext    = 4'b0001 << ALUResult_IN[1:0];
      wdataNext = {4{MemWriteData_IN[7:0]}};
    end else if (sizeHalf) begin
      beNext    = ALUResult_IN[1] ? 4'b1100 : 4'b0011;
      wdataNext = {2{MemWriteData_IN[15:0]}};
    end
  end

  // Lane select uses the captured address so the result tracks the access in flight.
  always_comb begin
    laneByte   = BUS_RDATA[{addrLow, 3'b000} +: 8];
    laneHalf   = addrLow[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];
    loadResult = BUS_RDATA;
    case (accType)
      OP_LB:   loadResult = {{24{laneByte[7]}}, laneByte};
      OP_LBU:  loadResult = {24'd0, laneByte};
      OP_LH:   loadResult = {{16{laneHalf[15]}}, laneHalf};
      OP_LHU:  loadResult = {16'd0, laneHalf};
      default: loadResult = BUS_RDATA;
    endcase
  end

  always_comb begin
    stateNext = state;
    cntNext   = timeoutCnt;
    abortNext = abortFlag;
    capture   = 1'b0;
    ackTake   = 1'b0;
    BUS_REQ   = 1'b0;
    MEM_STALL = 1'b0;
    MEM_ERROR = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (bad) begin
            MEM_ERROR = 1'b1;
          end else begin
            MEM_STALL = 1'b1;
            capture   = 1'b1;
            cntNext   = 8'd0;
            stateNext = BUSY;
          end
        end
      end
      BUSY: begin
        BUS_REQ   = 1'b1;
        MEM_STALL = 1'b1;
        if (BUS_ACK) begin
          ackTake   = 1'b1;
          stateNext = DONE;
        end else begin
          cntNext = cntInc;
          if (TIMEOUT_LIMIT != 8'd0 && cntInc == TIMEOUT_LIMIT) begin
            abortNext = 1'b1;
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        MEM_ERROR = abortFlag;
        abortNext = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state           <= IDLE;
      timeoutCnt      <= 8'd0;
      abortFlag       <= 1'b0;
      accType         <= 6'd0;
      addrLow         <= 2'd0;
      BUS_WE          <= 1'b0;
      BUS_ADDR        <= 32'd0;
      BUS_BE          <= 4'd0;
      BUS_WDATA       <= 32'd0;
      MemReadData_OUT <= 32'd0;
    end else begin
      state      <= stateNext;
      timeoutCnt <= cntNext;
      abortFlag  <= abortNext;
      if (capture) begin
        accType   <= MemControl_IN;
        addrLow   <= ALUResult_IN[1:0];
        BUS_WE    <= MemWrite_IN;
        BUS_ADDR  <= {ALUResult_IN[31:2], 2'b00};
        BUS_BE    <= beNext;
        BUS_WDATA <= wdataNext;
      end
      if (ackTake && !BUS_WE) begin
        MemReadData_OUT <= loadResult;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with randomized accesses
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] MemWriteData_IN;
  logic [5:0]  MemControl_IN;
  logic        MemRead_IN, MemWrite_IN;
  logic [31:0] ALUResult_IN;
  logic [4:0]  WriteRegister_IN;
  logic        WriteEnable_IN;
  logic        BUS_REQ, BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [3:0]  BUS_BE;
  logic [31:0] BUS_WDATA;
  logic [31:0] BUS_RDATA;
  logic        BUS_ACK;
  logic        MEM_STALL, MEM_ERROR;
  logic [31:0] MemReadData_OUT, ALUResult_OUT;
  logic [4:0]  WriteRegister_OUT;
  logic        WriteEnable_OUT;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .MemWriteData_IN(MemWriteData_IN), .MemControl_IN(MemControl_IN),
    .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
    .ALUResult_IN(ALUResult_IN), .WriteRegister_IN(WriteRegister_IN),
    .WriteEnable_IN(WriteEnable_IN),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
    .MEM_STALL(MEM_STALL), .MEM_ERROR(MEM_ERROR),
    .MemReadData_OUT(MemReadData_OUT), .ALUResult_OUT(ALUResult_OUT),
    .WriteRegister_OUT(WriteRegister_OUT), .WriteEnable_OUT(WriteEnable_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit          immErr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          reqCycles;
    logic        err;
    logic        weOut;
    logic [31:0] rdata;
  } expT;

  expT         sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastLoad = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 when the code is not a memory op.
  function automatic int accSize(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit isLoad(input logic [5:0] op);
    return op inside {6'h20, 6'h24, 6'h21, 6'h25, 6'h23};
  endfunction

  function automatic bit isStore(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic bit modelBad(input bit rd, input bit wr, input logic [5:0] op, input logic [31:0] addr);
    int sz;
    sz = accSize(op);
    if (rd && wr) return 1;
    if (rd && !isLoad(op)) return 1;
    if (wr && !isStore(op)) return 1;
    if (sz == 0) return 1;
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (addr % 4));
    case (accSize(op))
      1: begin
        v = v & 32'hFF;
        if (op == 6'h20 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      2: begin
        v = v & 32'hFFFF;
        if (op == 6'h21 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // Drive one instruction from an IDLE cycle (called at posedge+1); returns at posedge+1 of the following IDLE.
  task automatic issue(input logic [5:0] op, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input bit wen, input int waits, input logic [31:0] rdata);
    expT e;
    int  sz;
    bit  acked;
    MemControl_IN    = op;
    MemRead_IN       = rd;
    MemWrite_IN      = wr;
    ALUResult_IN     = addr;
    MemWriteData_IN  = data;
    WriteEnable_IN   = wen;
    WriteRegister_IN = 5'($urandom);
    BUS_ACK          = 1'b0;
    BUS_RDATA        = $urandom;
    if (!(rd || wr)) begin
      @(posedge CLOCK); #1;
    end else if (modelBad(rd, wr, op, addr)) begin
      e = '{immErr: 1'b1, addr: 32'd0, be: 4'd0, we: 1'b0, wdata: 32'd0,
            reqCycles: 0, err: 1'b1, weOut: 1'b0, rdata: 32'd0};
      sbq.push_back(e);
      @(posedge CLOCK); #1;
    end else begin
      sz    = accSize(op);
      acked = (waits < TMO);
      if (acked && rd) lastLoad = modelLoad(op, addr, rdata);
      e.immErr    = 1'b0;
      e.addr      = addr & ~32'd3;
      e.be        = 4'(((1 << sz) - 1) << (addr % 4));
      e.we        = wr;
      e.wdata     = (sz == 1) ? data[7:0] * 32'h01010101 :
                    (sz == 2) ? data[15:0] * 32'h00010001 : data;
      e.reqCycles = acked ? waits + 1 : TMO;
      e.err       = !acked;
      e.weOut     = wen && acked;
      e.rdata     = lastLoad;
      sbq.push_back(e);
      @(posedge CLOCK); #1;
      for (int i = 1; i <= e.reqCycles; i++) begin
        BUS_ACK   = acked && (i == waits + 1);
        BUS_RDATA = BUS_ACK ? rdata : $urandom;
        @(posedge CLOCK); #1;
      end
      BUS_ACK   = 1'($urandom_range(0, 1));
      BUS_RDATA = $urandom;
      @(posedge CLOCK); #1;
      BUS_ACK   = 1'b0;
    end
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_req"},   {31'd0, BUS_REQ},   32'd0);
    check({tag, "_we"},    {31'd0, BUS_WE},    32'd0);
    check({tag, "_stall"}, {31'd0, MEM_STALL}, 32'd0);
    check({tag, "_err"},   {31'd0, MEM_ERROR}, 32'd0);
    check({tag, "_addr"},  BUS_ADDR,           32'd0);
    check({tag, "_be"},    {28'd0, BUS_BE},    32'd0);
    check({tag, "_wdata"}, BUS_WDATA,          32'd0);
    check({tag, "_rdata"}, MemReadData_OUT,    32'd0);
  endtask

  // Monitor: observes bus transactions and error pulses, pops the scoreboard on each completion.
  logic        prevReq = 1'b0;
  int          reqRun = 0, stallRun = 0;
  logic [31:0] obsAddr, obsWdata;
  logic [3:0]  obsBe;
  logic        obsWe;

  always @(negedge CLOCK) begin
    expT e;
    if (RESET) begin
      prevReq  = 1'b0;
      reqRun   = 0;
      stallRun = 0;
    end else begin
      check("alu_pass", ALUResult_OUT, ALUResult_IN);
      check("wreg_pass", {27'd0, WriteRegister_OUT}, {27'd0, WriteRegister_IN});
      if (BUS_REQ) begin
        if (!prevReq) begin
          obsAddr = BUS_ADDR; obsBe = BUS_BE; obsWe = BUS_WE; obsWdata = BUS_WDATA;
        end else begin
          check("bus_hold", BUS_ADDR ^ BUS_WDATA ^ {27'd0, BUS_WE, BUS_BE},
                obsAddr ^ obsWdata ^ {27'd0, obsWe, obsBe});
        end
        check("busy_stall", {31'd0, MEM_STALL}, 32'd1);
        reqRun++;
        if (reqRun > 20) begin
          check("req_bound", 32'(reqRun), 32'd20);
          reqRun = 0;
        end
      end else if (prevReq) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("done_kind", {31'd0, e.immErr}, 32'd0);
          check("bus_addr", obsAddr, e.addr);
          check("bus_be", {28'd0, obsBe}, {28'd0, e.be});
          check("bus_we", {31'd0, obsWe}, {31'd0, e.we});
          if (e.we) check("bus_wdata", obsWdata, e.wdata);
          check("req_cycles", 32'(reqRun), 32'(e.reqCycles));
          check("stall_cycles", 32'(stallRun), 32'(e.reqCycles + 1));
          check("done_stall", {31'd0, MEM_STALL}, 32'd0);
          check("done_error", {31'd0, MEM_ERROR}, {31'd0, e.err});
          check("done_wen", {31'd0, WriteEnable_OUT}, {31'd0, e.weOut});
          check("load_data", MemReadData_OUT, e.rdata);
        end
        reqRun = 0;
      end else if (MEM_ERROR) begin
        if (sbq.size() == 0) begin
          check("unexpected_error", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("err_kind", {31'd0, e.immErr}, 32'd1);
          check("err_stall", {31'd0, MEM_STALL}, 32'd0);
          check("err_wen", {31'd0, WriteEnable_OUT}, 32'd0);
        end
      end
      stallRun = MEM_STALL ? stallRun + 1 : 0;
      prevReq  = BUS_REQ;
    end
  end

  logic [5:0] opTable [8] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B};

  initial begin
    logic [5:0]  op;
    bit          rd, wr;
    int          mode;
    RESET = 1'b1;
    MemWriteData_IN = 32'd0; MemControl_IN = 6'd0; MemRead_IN = 1'b0; MemWrite_IN = 1'b0;
    ALUResult_IN = 32'd0; WriteRegister_IN = 5'd0; WriteEnable_IN = 1'b0;
    BUS_RDATA = 32'd0; BUS_ACK = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    @(negedge CLOCK);
    checkResetValues("reset");
    @(posedge CLOCK); #1;
    RESET = 1'b0;

    issue(6'h23, 1, 0, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF);
    check("lw_value", MemReadData_OUT, 32'hDEADBEEF);
    issue(6'h20, 1, 0, 32'h103, 32'h0, 1, 1, 32'h80FF0000);
    check("lb_value", MemReadData_OUT, 32'hFFFFFF80);
    issue(6'h24, 1, 0, 32'h103, 32'h0, 1, 0, 32'h80FF0000);
    check("lbu_value", MemReadData_OUT, 32'h00000080);
    issue(6'h21, 1, 0, 32'h102, 32'h0, 1, 2, 32'h80FF0000);
    check("lh_value", MemReadData_OUT, 32'hFFFF80FF);
    issue(6'h29, 0, 1, 32'h206, 32'h1234ABCD, 0, 3, 32'h0);
    issue(6'h23, 1, 0, 32'h101, 32'h0, 1, 0, 32'h0);
    issue(6'h2B, 0, 1, 32'h300, 32'h55AA55AA, 1, TMO, 32'h0);
    issue(6'h23, 1, 0, 32'h000, 32'h0, 1, 0, 32'h0);

    // Reset in the second BUSY cycle, then a late ack that must be ignored.
    MemControl_IN = 6'h23; MemRead_IN = 1'b1; MemWrite_IN = 1'b0; ALUResult_IN = 32'h400;
    issue(6'h23, 1, 0, 32'h104, 32'h0, 1, 0, 32'h13579BDF);
    MemControl_IN = 6'h23; MemRead_IN = 1'b1; ALUResult_IN = 32'h400;
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0; MemRead_IN = 1'b0;
    BUS_ACK = 1'b1; BUS_RDATA = 32'hCAFEF00D;
    lastLoad = 32'd0;
    @(negedge CLOCK);
    checkResetValues("midreset");
    @(posedge CLOCK); #1;
    BUS_ACK = 1'b0;
    @(negedge CLOCK);
    check("late_ack_req", {31'd0, BUS_REQ}, 32'd0);
    check("late_ack_data", MemReadData_OUT, 32'd0);
    @(posedge CLOCK); #1;

    for (int n = 0; n < 300; n++) begin
      op   = opTable[$urandom_range(0, 7)];
      mode = $urandom_range(0, 19);
      rd   = isLoad(op);
      wr   = isStore(op);
      if (mode == 0) begin rd = 1; wr = 1; end
      else if (mode == 1) begin rd = !rd; wr = !wr; end
      else if (mode == 2) begin rd = 0; wr = 0; end
      else if (mode == 3) op = 6'($urandom);
      issue(op, rd, wr, $urandom, $urandom, 1'($urandom), $urandom_range(0, 5), $urandom);
    end

    MemRead_IN = 1'b0; MemWrite_IN = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
